branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 15 +
 rtl/comparator_n_bit.sv | 23 ++
 rtl/branch_resolver.sv | 133 +++++++++++++
 tb/tb_branch_resolver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver slice:
// branch funct3 encodings and mispredict counter width.
package branch_resolver_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/comparator_n_bit.sv
// N-bit magnitude comparator, signed or unsigned.
// Ports: a_i, b_i, signed_i in; lt_o, eq_o, gt_o out.
module comparator_n_bit #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         signed_i,
  output logic         lt_o,
  output logic         eq_o,
  output logic         gt_o
);

  logic lt_s;
  logic lt_u;

  assign lt_s = $signed(a_i) < $signed(b_i);
  assign lt_u = a_i < b_i;
  assign eq_o = a_i == b_i;
  assign lt_o = signed_i ? lt_s : lt_u;
  assign gt_o = !lt_o && !eq_o;

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional branches with a one-entry output register.
// Ports: clk, rst_n; in_valid/in_ready request with rs1, rs2,
// funct3, pc, imm, pred_taken; flush; out_valid/out_ready result
// with taken, next_pc, mispredict, illegal; mispredict_count.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  next_pc,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] mispredict_count
);

  logic            lt;
  logic            eq;
  logic            gt;
  logic            sgn;
  logic            tk_c;
  logic            ill_c;
  logic [XLEN-1:0] npc_c;
  logic            mis_c;

  logic            accept;
  logic            xfer;

  logic             valid_q, valid_d;
  logic             tk_q, tk_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic             mis_q, mis_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sgn = (funct3 == F3_BLT) || (funct3 == F3_BGE);

  comparator_n_bit #(
    .N(XLEN)
  ) u_cmp (
    .a_i     (rs1),
    .b_i     (rs2),
    .signed_i(sgn),
    .lt_o    (lt),
    .eq_o    (eq),
    .gt_o    (gt)
  );

  always_comb begin
    tk_c  = 1'b0;
    ill_c = 1'b0;
    unique case (funct3)
      F3_BEQ:  tk_c = eq;
      F3_BNE:  tk_c = !eq;
      F3_BLT:  tk_c = lt;
      F3_BGE:  tk_c = gt || eq;
      F3_BLTU: tk_c = lt;
      F3_BGEU: tk_c = gt || eq;
      default: ill_c = 1'b1;
    endcase
  end

  assign npc_c = tk_c ? (pc + imm) : (pc + XLEN'(4));
  assign mis_c = tk_c ^ pred_taken;

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    tk_d    = tk_q;
    npc_d   = npc_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      tk_d  = tk_c;
      npc_d = npc_c;
      mis_d = mis_c;
      ill_d = ill_c;
    end
    if (xfer && mis_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tk_q    <= 1'b0;
      npc_q   <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tk_q    <= tk_d;
      npc_q   <= npc_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid        = valid_q;
  assign taken            = tk_q;
  assign next_pc          = npc_q;
  assign mispredict       = mis_q;
  assign illegal          = ill_q;
  assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
// Linear stimulus with hand-computed expected values.
module tb_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] imm;
  logic        pred_taken;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        taken;
  logic [31:0] next_pc;
  logic        mispredict;
  logic        illegal;
  logic [15:0] mispredict_count;

  int total;
  int bad;

  branch_resolver #(
    .XLEN(32)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .rs1             (rs1),
    .rs2             (rs2),
    .funct3          (funct3),
    .pc              (pc),
    .imm             (imm),
    .pred_taken      (pred_taken),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .taken           (taken),
    .next_pc         (next_pc),
    .mispredict      (mispredict),
    .illegal         (illegal),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] p,
                     input logic [31:0] i,
                     input logic pt);
    funct3     = f3;
    rs1        = a;
    rs2        = b;
    pc         = p;
    imm        = i;
    pred_taken = pt;
  endtask

  task automatic chk_out(input string tag,
                         input logic v,
                         input logic t,
                         input logic [31:0] np,
                         input logic m,
                         input logic il);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".taken"}, 32'(taken), 32'(t));
    chk({tag, ".npc"}, next_pc, np);
    chk({tag, ".mis"}, 32'(mispredict), 32'(m));
    chk({tag, ".ill"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    req(3'b000, 0, 0, 0, 0, 1'b0);

    tick();
    tick();
    chk_out("rst", 0, 0, 32'h0, 0, 0);
    chk("rst.cnt", 32'(mispredict_count), 0);
    chk("rst.rdy", 32'(in_ready), 1);

    // release between edges; first edge after must accept
    #2 rst_n = 1'b1;

    // signed BLT: -1 < 1
    in_valid = 1'b1;
    req(3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1);
    tick();
    chk_out("blt", 1, 1, 32'h120, 0, 0);

    // unsigned BLTU: 0xFFFFFFFF > 1
    req(3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b1);
    tick();
    chk_out("bltu", 1, 0, 32'h104, 1, 0);
    chk("bltu.cnt", 32'(mispredict_count), 0);

    // BEQ with pc+imm wrap
    req(3'b000, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1);
    tick();
    chk_out("beqw", 1, 1, 32'h4, 0, 0);
    chk("beqw.cnt", 32'(mispredict_count), 1);

    // BNE not taken, pc+4 wrap
    req(3'b001, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b0);
    tick();
    chk_out("bnew", 1, 0, 32'h0, 0, 0);

    // BGE equal operands, negative offset
    req(3'b101, 32'h3, 32'h3, 32'h200, 32'hFFFF_FFF0, 1'b1);
    tick();
    chk_out("bge", 1, 1, 32'h1F0, 0, 0);

    // BGEU: 1 < 0xFFFFFFFF unsigned so not taken
    req(3'b111, 32'h1, 32'hFFFF_FFFF, 32'h200, 32'h40, 1'b0);
    tick();
    chk_out("bgeu", 1, 0, 32'h204, 0, 0);

    // illegal funct3 010 with predicted taken
    req(3'b010, 32'h7, 32'h7, 32'h300, 32'h40, 1'b1);
    tick();
    chk_out("ill", 1, 0, 32'h304, 1, 1);
    chk("ill.cnt0", 32'(mispredict_count), 1);

    in_valid = 1'b0;
    tick();
    chk("ill.vld", 32'(out_valid), 0);
    chk("ill.cnt1", 32'(mispredict_count), 2);

    // stall: hold R1 for 3 cycles while new request waits
    out_ready = 1'b0;
    in_valid  = 1'b1;
    req(3'b000, 32'h1, 32'h1, 32'h300, 32'h40, 1'b0);
    tick();
    chk_out("r1", 1, 1, 32'h340, 1, 0);
    req(3'b001, 32'h1, 32'h0, 32'h410, 32'h8, 1'b1);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall.rdy", 32'(in_ready), 0);
      tick();
      chk_out("stall", 1, 1, 32'h340, 1, 0);
      chk("stall.cnt", 32'(mispredict_count), 2);
    end

    // release: 4 back-to-back requests, one per cycle
    out_ready = 1'b1;
    #1;
    chk("go.rdy", 32'(in_ready), 1);
    tick();
    chk_out("b2b1", 1, 1, 32'h418, 0, 0);
    chk("b2b.cnt", 32'(mispredict_count), 3);
    req(3'b001, 32'h2, 32'h0, 32'h420, 32'h8, 1'b1);
    tick();
    chk_out("b2b2", 1, 1, 32'h428, 0, 0);
    req(3'b001, 32'h3, 32'h0, 32'h430, 32'h8, 1'b1);
    tick();
    chk_out("b2b3", 1, 1, 32'h438, 0, 0);
    req(3'b001, 32'h4, 32'h0, 32'h440, 32'h8, 1'b1);
    tick();
    chk_out("b2b4", 1, 1, 32'h448, 0, 0);
    in_valid = 1'b0;
    tick();
    chk("b2b.end", 32'(out_valid), 0);
    chk("b2b.cnt2", 32'(mispredict_count), 3);

    // stream mispredicting BNE until count = 0xFFFE
    in_valid = 1'b1;
    req(3'b001, 32'h1, 32'h2, 32'h500, 32'h10, 1'b0);
    // first tick only accepts; each later tick adds one
    for (int k = 0; k < 65532; k++) tick();
    chk("pre.cnt", 32'(mispredict_count), 32'hFFFE);
    chk("pre.vld", 32'(out_valid), 1);

    // flush with valid result and ready consumer
    flush = 1'b1;
    #1;
    chk("fl.rdy", 32'(in_ready), 0);
    tick();
    chk("fl.vld", 32'(out_valid), 0);
    chk("fl.cnt", 32'(mispredict_count), 32'hFFFE);
    flush = 1'b0;

    tick();
    chk("sat.vld", 32'(out_valid), 1);
    chk("sat.cnt0", 32'(mispredict_count), 32'hFFFE);
    tick();
    chk("sat.cnt1", 32'(mispredict_count), 32'hFFFF);
    tick();
    chk("sat.cnt2", 32'(mispredict_count), 32'hFFFF);

    // async reset while result held
    chk_out("prerst", 1, 1, 32'h510, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst", 0, 0, 32'h0, 0, 0);
    chk("arst.cnt", 32'(mispredict_count), 0);
    #2 rst_n = 1'b1;
    req(3'b000, 32'h9, 32'h9, 32'h600, 32'h20, 1'b0);
    tick();
    chk_out("post", 1, 1, 32'h620, 1, 0);
    chk("post.cnt", 32'(mispredict_count), 0);
    in_valid = 1'b0;
    tick();
    chk("post.cnt1", 32'(mispredict_count), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
